// File: rtl/imem_loader.sv
// Purpose: assembles a byte-serial program image (16-bit BE word count + LE words) into instruction-memory writes.
// Latency: write strobe one cycle after the 4th byte of a word; done two cycles after the last byte (one for an empty image).
// Backpressure: in_ready drops for one bubble cycle per word (WRITE) and outside a load; stalled in_valid freezes progress.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle load request, only honoured while idle
//   in_data/in_valid/in_ready   byte stream, transfer when in_valid & in_ready
//   wr_en/wr_addr/wr_data instruction memory write port (BASE_ADDR + 4*word_index)
//   cpu_hold              stalls fetch from the cycle after start through the done cycle
//   done/load_error       completion pulse, error when the image exceeded DEPTH words
//   words_loaded          words actually written by the last load
module imem_loader #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [31:0]           asm_q, asm_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  load_error_q, load_error_d;
  logic [15:0]           words_loaded_q, words_loaded_d;
  logic                  xfer;
  logic [15:0]           words_min;

  assign in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign xfer     = in_valid && in_ready;

  // Words actually written: the count is clipped at the memory depth.
  assign words_min = ({16'b0, n_q} > DEPTH_W) ? DEPTH_W[15:0] : n_q;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    byte_cnt_d     = byte_cnt_q;
    word_idx_d     = word_idx_q;
    asm_d          = asm_q;
    ovf_d          = ovf_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_HDR0;
          words_loaded_d = 16'd0;
          ovf_d          = 1'b0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d[7:0]   = in_data;
          byte_cnt_d = 2'd0;
          word_idx_d = 16'd0;
          if ({n_q[15:8], in_data} == 16'd0) begin
            state_d        = S_DONE;
            words_loaded_d = 16'd0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
            // The write is launched here so the strobe lands in the WRITE cycle itself.
            if ({16'b0, word_idx_q} < DEPTH_W) begin
              wr_en_d   = 1'b1;
              wr_addr_d = BASE_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
              wr_data_d = {in_data, asm_q[23:0]};
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if ((word_idx_q + 16'd1) == n_q) begin
          state_d        = S_DONE;
          words_loaded_d = words_min;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered status outputs follow the next state so they line up with it.
    cpu_hold_d   = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    load_error_d = (state_d == S_DONE) && ovf_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      byte_cnt_q     <= '0;
      word_idx_q     <= '0;
      asm_q          <= '0;
      ovf_q          <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      byte_cnt_q     <= byte_cnt_d;
      word_idx_q     <= word_idx_d;
      asm_q          <= asm_d;
      ovf_q          <= ovf_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      load_error_q   <= load_error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances share one stimulus stream, one with default
// parameters and one small (DEPTH=4, BASE_ADDR=0x100) so overflow is exercised.
// A frame-level model predicts every output on every cycle; directed tests add literal checks.
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic [1:0]  in_ready_w, wr_en_w, cpu_hold_w, done_w, load_error_w;
  logic [63:0] wr_addr_w [2];
  logic [31:0] wr_data_w [2];
  logic [15:0] wl_w [2];

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(64), .BASE_ADDR(64'h0), .DEPTH(256)) dut0 (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
    .cpu_hold(cpu_hold_w[0]), .done(done_w[0]), .load_error(load_error_w[0]), .words_loaded(wl_w[0])
  );

  imem_loader #(.ADDR_WIDTH(64), .BASE_ADDR(64'h100), .DEPTH(4)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
    .cpu_hold(cpu_hold_w[1]), .done(done_w[1]), .load_error(load_error_w[1]), .words_loaded(wl_w[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  int          depth_m [2] = '{256, 4};
  logic [63:0] base_m  [2] = '{64'h0, 64'h100};

  bit          mon_en = 1'b0;
  bit          active;
  int          done_cyc, bubble_cyc, hold_from;
  int          hdr_cnt, n_m, bytes_left, biw, word_k;
  logic [31:0] asm_m;
  bit          e_wr [2];
  logic [63:0] e_addr [2], last_addr [2];
  logic [31:0] e_data [2], last_data [2];
  int          e_wl [2];

  // DUT-observed history used by the directed literal checks
  logic [63:0] cap_addr [2][64];
  logic [31:0] cap_data [2][64];
  int          wr_cnt [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          done_seen [2] = '{0, 0};
  bit          err_seen [2];
  int          last_xfer = 0;

  task automatic model_reset();
    active = 1'b0; done_cyc = -1; bubble_cyc = -1; hold_from = 0;
    hdr_cnt = 0; n_m = 0; bytes_left = 0; biw = 0; word_k = 0; asm_m = '0;
    for (int d = 0; d < 2; d++) begin
      e_wr[d] = 1'b0; e_addr[d] = '0; e_data[d] = '0;
      last_addr[d] = '0; last_data[d] = '0; e_wl[d] = 0;
    end
  endtask

  task automatic consume(input logic [7:0] b);
    if (hdr_cnt == 0) begin
      n_m = int'(b) * 256;
      hdr_cnt = 1;
    end else if (hdr_cnt == 1) begin
      n_m = n_m + int'(b);
      hdr_cnt = 2;
      bytes_left = 4 * n_m;
      biw = 0; word_k = 0;
      if (n_m == 0) done_cyc = cyc + 1;
    end else begin
      asm_m[8*biw +: 8] = b;
      biw++;
      bytes_left--;
      if (biw == 4) begin
        for (int d = 0; d < 2; d++) begin
          if (word_k < depth_m[d]) begin
            e_wr[d]   = 1'b1;
            e_addr[d] = base_m[d] + 64'(4 * word_k);
            e_data[d] = asm_m;
          end
        end
        bubble_cyc = cyc + 1;
        word_k++;
        biw = 0;
        if (bytes_left == 0) done_cyc = cyc + 2;
      end
    end
  endtask

  always @(negedge clock) begin
    bit act_c, rdy_e, hold_e;
    if (!mon_en) begin
      if (reset) begin
        model_reset();
        mon_en = 1'b1;
      end
    end else begin
      act_c = active;
      if (cyc == done_cyc)
        for (int d = 0; d < 2; d++) e_wl[d] = (n_m < depth_m[d]) ? n_m : depth_m[d];
      rdy_e  = active && (cyc >= hold_from) && (hdr_cnt < 2 || bytes_left > 0) && (cyc != bubble_cyc);
      hold_e = active && (cyc >= hold_from);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready%0d", d), 64'(in_ready_w[d]), 64'(rdy_e));
        chk($sformatf("cpu_hold%0d", d), 64'(cpu_hold_w[d]), 64'(hold_e));
        chk($sformatf("done%0d", d), 64'(done_w[d]), 64'(cyc == done_cyc));
        chk($sformatf("load_error%0d", d), 64'(load_error_w[d]),
            64'((cyc == done_cyc) && (n_m > depth_m[d])));
        chk($sformatf("words_loaded%0d", d), 64'(wl_w[d]), 64'(e_wl[d]));
        chk($sformatf("wr_en%0d", d), 64'(wr_en_w[d]), 64'(e_wr[d]));
        if (e_wr[d]) begin
          last_addr[d] = e_addr[d];
          last_data[d] = e_data[d];
        end
        chk($sformatf("wr_addr%0d", d), wr_addr_w[d], last_addr[d]);
        chk($sformatf("wr_data%0d", d), 64'(wr_data_w[d]), 64'(last_data[d]));
        if (wr_en_w[d] === 1'b1 && wr_cnt[d] < 64) begin
          cap_addr[d][wr_cnt[d]] = wr_addr_w[d];
          cap_data[d][wr_cnt[d]] = wr_data_w[d];
          wr_cnt[d]++;
        end
        if (done_w[d] === 1'b1) begin
          done_cnt[d]++;
          done_seen[d] = cyc;
          err_seen[d]  = load_error_w[d];
        end
        e_wr[d] = 1'b0;
      end
      if (cyc == done_cyc) begin
        active = 1'b0;
        done_cyc = -1;
      end
      if (reset) begin
        model_reset();
      end else if (!act_c && start) begin
        active = 1'b1; hold_from = cyc + 1; hdr_cnt = 0; bytes_left = 0;
        for (int d = 0; d < 2; d++) e_wl[d] = 0;
      end else if (act_c && in_valid && rdy_e) begin
        consume(in_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit with_start);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) next_cycle();
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      ok = in_ready_w[0];
      if (ok) last_xfer = cyc;
      next_cycle();
      start = 1'b0;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send(w[8*j +: 8], 0, 1'b0);
  endtask

  task automatic wait_done(input int base_cnt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_cnt[0] > base_cnt) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within budget");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, dc, pos;
    logic [31:0] gw [2];

    // Reset
    repeat (3) next_cycle();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready_w[0]), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold_w[0]), 64'd0);
    chk("rst_wr_addr", wr_addr_w[1], 64'd0);
    chk("rst_words_loaded", 64'(wl_w[0]), 64'd0);
    next_cycle();

    // Basic load
    w0 = wr_cnt[0]; w1 = wr_cnt[1]; dc = done_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h02, 0, 1'b0);
    send_word(32'h12345678); send_word(32'hDEADBEEF);
    wait_done(dc);
    chk("basic_nwr", 64'(wr_cnt[0] - w0), 64'd2);
    chk("basic_addr0", cap_addr[0][w0], 64'h0);
    chk("basic_data0", 64'(cap_data[0][w0]), 64'h12345678);
    chk("basic_addr1", cap_addr[0][w0+1], 64'h4);
    chk("basic_data1", 64'(cap_data[0][w0+1]), 64'hDEADBEEF);
    chk("basic_small_addr1", cap_addr[1][w1+1], 64'h104);
    chk("basic_done_lat", 64'(done_seen[0] - last_xfer), 64'd2);
    chk("basic_err", 64'(err_seen[0]), 64'd0);
    chk("basic_wl", 64'(wl_w[0]), 64'd2);
    chk("basic_hold_fall", 64'(cpu_hold_w[0]), 64'd0);
    repeat (2) next_cycle();

    // Zero count
    w0 = wr_cnt[0]; dc = done_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h00, 0, 1'b0);
    wait_done(dc);
    chk("zero_nwr", 64'(wr_cnt[0] - w0), 64'd0);
    chk("zero_done_lat", 64'(done_seen[0] - last_xfer), 64'd1);
    chk("zero_wl", 64'(wl_w[0]), 64'd0);
    repeat (2) next_cycle();

    // Idle gaps inside each word
    w0 = wr_cnt[0]; dc = done_cnt[0];
    gw[0] = 32'h12345678; gw[1] = 32'hDEADBEEF;
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h02, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      pos = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) send(gw[k][8*j +: 8], (j == pos) ? 3 : 0, 1'b0);
    end
    wait_done(dc);
    chk("gap_nwr", 64'(wr_cnt[0] - w0), 64'd2);
    chk("gap_data0", 64'(cap_data[0][w0]), 64'h12345678);
    chk("gap_data1", 64'(cap_data[0][w0+1]), 64'hDEADBEEF);
    repeat (2) next_cycle();

    // Overflow on the DEPTH=4 instance
    w0 = wr_cnt[0]; w1 = wr_cnt[1]; dc = done_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h06, 0, 1'b0);
    for (int k = 0; k < 6; k++) send_word(32'hC0DE0000 + 32'(k));
    wait_done(dc);
    chk("ovf_nwr_small", 64'(wr_cnt[1] - w1), 64'd4);
    chk("ovf_addr_first", cap_addr[1][w1], 64'h100);
    chk("ovf_addr_last", cap_addr[1][w1+3], 64'h10C);
    chk("ovf_data_last", 64'(cap_data[1][w1+3]), 64'hC0DE0003);
    chk("ovf_err_small", 64'(err_seen[1]), 64'd1);
    chk("ovf_wl_small", 64'(wl_w[1]), 64'd4);
    chk("ovf_done_same", 64'(done_seen[1]), 64'(done_seen[0]));
    chk("ovf_nwr_big", 64'(wr_cnt[0] - w0), 64'd6);
    chk("ovf_err_big", 64'(err_seen[0]), 64'd0);
    chk("ovf_wl_big", 64'(wl_w[0]), 64'd6);
    repeat (2) next_cycle();

    // Reset in the middle of word 1
    w0 = wr_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h02, 0, 1'b0);
    send_word(32'h44332211);
    send(8'h55, 0, 1'b0); send(8'h66, 0, 1'b0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk("mid_rst_wr_en", 64'(wr_en_w[0]), 64'd0);
    chk("mid_rst_hold", 64'(cpu_hold_w[0]), 64'd0);
    chk("mid_rst_ready", 64'(in_ready_w[0]), 64'd0);
    chk("mid_rst_addr", wr_addr_w[0], 64'd0);
    chk("mid_rst_data", 64'(wr_data_w[0]), 64'd0);
    repeat (4) next_cycle();
    chk("mid_rst_nwr", 64'(wr_cnt[0] - w0), 64'd1);
    w0 = wr_cnt[0]; dc = done_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h01, 0, 1'b0);
    send_word(32'h01020304);
    wait_done(dc);
    chk("fresh_nwr", 64'(wr_cnt[0] - w0), 64'd1);
    chk("fresh_addr", cap_addr[0][w0], 64'h0);
    chk("fresh_data", 64'(cap_data[0][w0]), 64'h01020304);
    chk("fresh_wl", 64'(wl_w[0]), 64'd1);
    repeat (2) next_cycle();

    // start while busy: during DATA, during WRITE, and in the DONE cycle
    w0 = wr_cnt[0]; dc = done_cnt[0];
    pulse_start();
    send(8'h00, 0, 1'b0); send(8'h02, 0, 1'b0);
    send(8'hA0, 0, 1'b1); send(8'hA1, 0, 1'b0); send(8'hA2, 0, 1'b0); send(8'hA3, 0, 1'b0);
    send(8'hB0, 0, 1'b1); send(8'hB1, 0, 1'b0); send(8'hB2, 0, 1'b0); send(8'hB3, 0, 1'b0);
    next_cycle();
    pulse_start();
    wait_done(dc);
    repeat (5) next_cycle();
    chk("busy_nwr", 64'(wr_cnt[0] - w0), 64'd2);
    chk("busy_data0", 64'(cap_data[0][w0]), 64'hA3A2A1A0);
    chk("busy_data1", 64'(cap_data[0][w0+1]), 64'hB3B2B1B0);
    chk("busy_ndone", 64'(done_cnt[0] - dc), 64'd1);
    chk("busy_idle_hold", 64'(cpu_hold_w[0]), 64'd0);
    chk("busy_idle_ready", 64'(in_ready_w[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
